muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit owning the HI/LO register pair, alongside the EX stage.
//  Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO in the background.
//  Exposes busy so the decoder stalls MFHI/MFLO and further muldiv ops.
//  Successor to the single-cycle HI/LO logic:
//  - parametrised width
//  - iterative multiplier and divider
//  - flush (abort) input
//  - divide-by-zero flag
// PARAMETERS
//  WIDTH     32  operand width; HI and LO are WIDTH bits each
//  MUL_BITS  4   multiplier bits retired per cycle; must divide WIDTH
// PORTS
//  CLK     in   1      clock, all state updates on rising edge
//  RST     in   1      synchronous, active-high reset
//  start   in   1      issue op this cycle (rs_val/rt_val/op valid)
//  op      in   3      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//  rs_val  in   WIDTH  rs operand (dividend/multiplicand/MTxx source)
//  rt_val  in   WIDTH  rt operand (divisor/multiplier)
//  flush   in   1      abort in-flight op (branch squash / exception)
//  busy    out  1      op in flight; start ignored while high
//  done    out  1      one-cycle pulse in the cycle HI/LO take a new result
//  div0    out  1      one-cycle pulse with done when divisor was zero
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div0=0, hi=0, lo=0; all working regs cleared.
//  FSM states: IDLE, MUL, DIV, FIX.
//  - IDLE, start & MTHI/MTLO: write hi/lo (rs_val) at that edge, done=1 next cycle, stay IDLE, busy stays 0.
//  - IDLE, start & MULT(U): latch |operands| (signed) or raw (unsigned) and result sign; -> MUL.
//  - IDLE, start & DIV(U): latch operands the same way; -> DIV.
//  - MUL: add/shift MUL_BITS per cycle; WIDTH/MUL_BITS cycles, then -> FIX.
//  - DIV: restoring radix-2, one quotient bit per cycle; WIDTH cycles, then -> FIX.
//  - FIX: apply signs; write {hi,lo} (mul) or lo=quot, hi=rem (div); done=1; -> IDLE.
//  Latency, start sampled at edge E0:
//  - busy=1 from E0 to E(N+1); done=1 and busy=0 after E(N+1).
//  - N=WIDTH/MUL_BITS for mul (8 at defaults), N=WIDTH for div (32).
//  Sign rules:
//  - mul: product sign = sign(rs)^sign(rt).
//  - div: quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
//  - signed MIN/-1: lo=MIN, hi=0, natural from magnitude arithmetic, no trap.
//  - Internal magnitudes are WIDTH+1 bits so |MIN| is representable.
//  - Product accumulator is 2*WIDTH bits.
//  Divide by zero: still runs the full N cycles; hi/lo left unchanged; done=1 and div0=1 in FIX.
//  Handshake:
//  - start while busy=1 is ignored, no queueing; the decoder guarantees stall.
//  - start with an undefined op code is ignored.
//  Flush:
//  - In MUL/DIV/FIX, -> IDLE next edge; hi/lo unchanged; done=0.
//  - flush in the same cycle as FIX wins: no write.
//  - flush in IDLE with start: op is dropped, including MTHI/MTLO.
//  RST has priority over everything at any point, including mid-operation.
//  hi/lo are readable at all times; while busy they hold the previous op's values.
// STRUCTURE
//  Shared include common_param.vh gains MD_MULT..MD_MTLO (3-bit) and MD_IDLE/MD_MUL/MD_DIV/MD_FIX state codes.
//  Sub-module div_step: combinational restoring step {rem,quot} -> {rem',quot'}, WIDTH+1-bit subtract.
//  Multiplier step stays inline.
// TESTING
//  1 RST=1 mid-DIV (cycle 10) -> next cycle busy=0, hi=lo=0, no done pulse.
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 9 edges hi=0xFFFFFFFE, lo=0x00000001, done=1.
//  3 MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 9 cycles.
//  4 DIV cases, each done after 33 edges:
//    - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 DIVU 5/0 with hi=0x11,lo=0x22 -> after 33 edges done=1, div0=1, hi=0x11, lo=0x22.
//  6 Flush and back-pressure cases:
//    - MULT then flush at cycle 4 -> busy=0 next cycle, hi/lo unchanged.
//    - start while busy ignored.
//    - MTLO 0xABCD in IDLE -> lo=0xABCD next edge, done pulse, busy stays 0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // State names carry an ST_ prefix so they never collide with the MD_DIV op code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic md_op_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH:0]   divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The remainder stays below the divisor, so once the WIDTH+1-bit compare says it
    // fits, the low WIDTH bits of the difference are the exact new remainder.
    always_comb begin
        rem_sh = {rem_i, quot_i[WIDTH-1]};
        fits   = (rem_sh >= divisor_i);
        diff   = rem_sh[WIDTH-1:0] - divisor_i[WIDTH-1:0];
        rem_o  = fits ? diff : rem_sh[WIDTH-1:0];
        quot_o = {quot_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Background multiply/divide unit owning HI/LO; iterative radix-2^MUL_BITS multiplier,
// restoring radix-2 divider, abortable by flush, flags divide-by-zero.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MUL_CYCLES = WIDTH / MUL_BITS;
    localparam int CNT_W      = $clog2(WIDTH);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     mag_a_q;
    logic [WIDTH:0]     mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic               is_mul_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               done_q;
    logic               div0_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     mag_a_w;
    logic [WIDTH:0]     mag_b_w;

    // Operand magnitudes are WIDTH+1 bits so that |MIN| is representable.
    always_comb begin
        signed_op = md_op_signed(op);
        a_neg     = signed_op & rs_val[WIDTH-1];
        b_neg     = signed_op & rt_val[WIDTH-1];
        a_ext     = {a_neg, rs_val};
        b_ext     = {b_neg, rt_val};
        mag_a_w   = a_neg ? -a_ext : a_ext;
        mag_b_w   = b_neg ? -b_ext : b_ext;
    end

    logic [MUL_BITS-1:0] digit;
    logic [2*WIDTH-1:0]  partial;
    logic [2*WIDTH-1:0]  acc_d;

    // Multiplier digits are consumed MSB-first, so the accumulator only ever shifts left.
    always_comb begin
        digit   = mag_b_q[WIDTH-1 -: MUL_BITS];
        partial = {{(WIDTH-1){1'b0}}, mag_a_q} * {{(2*WIDTH-MUL_BITS){1'b0}}, digit};
        acc_d   = (acc_q << MUL_BITS) + partial;
    end

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (mag_b_q),
        .rem_o     (rem_d),
        .quot_o    (quot_d)
    );

    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   quot_w;
    logic [WIDTH-1:0]   rem_w;

    always_comb begin
        prod_w = neg_q     ? -acc_q  : acc_q;
        quot_w = neg_q     ? -quot_q : quot_q;
        rem_w  = rem_neg_q ? -rem_q  : rem_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            is_mul_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MD_MTHI: begin
                                hi_q   <= rs_val;
                                done_q <= 1'b1;
                            end
                            MD_MTLO: begin
                                lo_q   <= rs_val;
                                done_q <= 1'b1;
                            end
                            MD_MULT, MD_MULTU: begin
                                mag_a_q   <= mag_a_w;
                                mag_b_q   <= mag_b_w;
                                acc_q     <= '0;
                                is_mul_q  <= 1'b1;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= 1'b0;
                                cnt_q     <= CNT_W'(MUL_CYCLES - 1);
                                state_q   <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                mag_a_q   <= mag_a_w;
                                mag_b_q   <= mag_b_w;
                                rem_q     <= '0;
                                quot_q    <= mag_a_w[WIDTH-1:0];
                                is_mul_q  <= 1'b0;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                cnt_q     <= CNT_W'(WIDTH - 1);
                                state_q   <= ST_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        mag_b_q <= mag_b_q << MUL_BITS;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    // A divide by zero still completes, but leaves HI/LO untouched.
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (is_mul_q) begin
                            hi_q <= prod_w[2*WIDTH-1:WIDTH];
                            lo_q <= prod_w[WIDTH-1:0];
                        end else if (mag_b_q == '0) begin
                            div0_q <= 1'b1;
                        end else begin
                            hi_q <= rem_w;
                            lo_q <= quot_w;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of ops plus flush/reset/back-pressure sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(W), .MUL_BITS(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_div0;
        int           exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one op and waits (bounded) for done; lat counts edges after the issue edge.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt, output logic d0, output logic busy_at_done);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        d0 = div0;
        busy_at_done = busy;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          pulses;
        logic        d0;
        logic        bz;

        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 9};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 9};
        vecs[2]  = '{MD_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 9};
        vecs[3]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 9};
        vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{MD_MTHI,  32'h00000011, 32'h0,        32'h00000011, 32'hFFFFFFFD, 1'b0, 0};
        vecs[9]  = '{MD_MTLO,  32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 1'b0, 0};
        vecs[10] = '{MD_DIVU,  32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1, 33};
        vecs[11] = '{MD_DIV,   32'h80000000, 32'd0,        32'h00000011, 32'h00000022, 1'b1, 33};
        vecs[12] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 9};

        RST = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        tick();
        tick();
        RST = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div0", 64'(div0), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bcnt, d0, bz);
            $display("vec %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h div0=%b lat=%0d busy_cycles=%0d",
                     i, vecs[i].op, vecs[i].rs, vecs[i].rt, hi, lo, d0, lat, bcnt);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d_div0", i), 64'(d0), 64'(vecs[i].exp_div0));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy_at_done", i), 64'(bz), 64'd0);
        end

        // Flush a MULT at cycle 4: unit idles next edge, HI/LO keep 0/1, no done later.
        op = MD_MULT; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("flush_mul: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("flush_mul_busy", 64'(busy), 64'd0);
        check("flush_mul_done", 64'(done), 64'd0);
        check("flush_mul_hi", 64'(hi), 64'd0);
        check("flush_mul_lo", 64'(lo), 64'd1);
        count_done(12, pulses);
        check("flush_mul_no_late_done", 64'(pulses), 64'd0);

        // Flush alongside an MTLO in IDLE drops the write.
        op = MD_MTLO; rs_val = 32'h55; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        $display("flush_idle_mtlo: done=%b lo=%h", done, lo);
        check("flush_idle_done", 64'(done), 64'd0);
        check("flush_idle_lo", 64'(lo), 64'd1);

        // Start while busy is ignored: MULTU 2*3 completes on schedule, no second op.
        op = MD_MULTU; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        $display("start_while_busy: hi=%h lo=%h lat=%0d", hi, lo, lat);
        check("busy_ignore_latency", 64'(lat), 64'd9);
        check("busy_ignore_hi", 64'(hi), 64'd0);
        check("busy_ignore_lo", 64'(lo), 64'd6);
        count_done(40, pulses);
        check("busy_ignore_no_second_done", 64'(pulses), 64'd0);
        check("busy_ignore_idle", 64'(busy), 64'd0);

        // Undefined op code is ignored.
        op = 3'd6; rs_val = 32'hDEAD; rt_val = 32'hBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        $display("undef_op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("undef_busy", 64'(busy), 64'd0);
        check("undef_done", 64'(done), 64'd0);
        check("undef_lo", 64'(lo), 64'd6);

        // Flush while in FIX wins over the write.
        op = MD_MULTU; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("fix_still_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("flush_fix: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("flush_fix_done", 64'(done), 64'd0);
        check("flush_fix_busy", 64'(busy), 64'd0);
        check("flush_fix_lo", 64'(lo), 64'd6);

        // MTLO in IDLE: LO written at the issue edge, done pulse, never busy.
        op = MD_MTLO; rs_val = 32'hABCD; start = 1'b1;
        tick();
        start = 1'b0;
        $display("mtlo: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_done", 64'(done), 64'd1);
        check("mtlo_busy", 64'(busy), 64'd0);
        tick();
        check("mtlo_done_one_cycle", 64'(done), 64'd0);

        // Reset at cycle 10 of a DIV clears everything with no done pulse.
        op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        $display("rst_mid_div: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        count_done(40, pulses);
        check("rst_mid_no_done", 64'(pulses), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
